spi_slave_cfg: RTL

Parametrised SPI slave: WIDTH-bit words, all four SPI modes selected at run time, MSB- or LSB-first order, and back-to-back words within one CS frame. Runs on the system clock (CLK) and oversamples the external SCLK/CS/SDI pins through synchronisers. It sits between the SPI pins and the host logic. On the host side it has a one-deep TX holding register with a ready/load handshake, an RX register with a valid/ack handshake, and sticky error flags. It supersedes the fixed 8-bit, SCLK-clocked slave.

---
 rtl/spi_slave_cfg.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_cfg.sv
// spi_slave_cfg: SPI slave oversampled on CLK. Run-time SPI mode, MSB/LSB-first words,
// back-to-back words per CS frame, one-deep TX holding register, RX valid/ack and sticky errors.
module spi_slave_cfg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             rx_overrun,
  output logic             tx_underrun,
  output logic             frame_err,
  input  logic             clr_err,
  output logic             busy,
  input  logic             SCLK,
  input  logic             CS,
  input  logic             SDI,
  output logic             SDO
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  // Pin synchronisers ([1] is the synchronised value) and delayed copies for edge detection
  logic [1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, sdi_sync_q, sdi_sync_d;
  logic       sclk_dly_q, sclk_dly_d, cs_dly_q, cs_dly_d;

  // Frame, shifter and host-side state
  logic             active_q, active_d;
  logic [1:0]       mode_q, mode_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             pend_q, pend_d;          // CPHA=1: first bit waits for the first shift edge
  logic             word_done_q, word_done_d;
  logic             under_pend_q, under_pend_d; // zero word loaded; flag once it is clocked out
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic             hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
  logic             rx_overrun_q, rx_overrun_d, tx_underrun_q, tx_underrun_d;
  logic             frame_err_q, frame_err_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, lead_ev, trail_ev, sample_ev, shift_ev;
  logic rx_new, load_tx, under_ev, over_ev, ferr_ev;

  // Synchroniser next state
  always_comb begin
    sclk_sync_d = {sclk_sync_q[0], SCLK};
    cs_sync_d   = {cs_sync_q[0], CS};
    sdi_sync_d  = {sdi_sync_q[0], SDI};
    sclk_dly_d  = sclk_sync_q[1];
    cs_dly_d    = cs_sync_q[1];
  end

  // Edge roles follow the mode latched at frame start
  always_comb begin
    sclk_rise = sclk_sync_q[1] & ~sclk_dly_q;
    sclk_fall = ~sclk_sync_q[1] & sclk_dly_q;
    cs_fall   = ~cs_sync_q[1] & cs_dly_q;
    cs_rise   = cs_sync_q[1] & ~cs_dly_q;
    lead_ev   = mode_q[1] ? sclk_fall : sclk_rise;
    trail_ev  = mode_q[1] ? sclk_rise : sclk_fall;
    sample_ev = active_q & (mode_q[0] ? trail_ev : lead_ev);
    shift_ev  = active_q & (mode_q[0] ? lead_ev : trail_ev);
  end

  // Frame control, shifters, holding register and host handshakes
  always_comb begin
    active_d     = active_q;
    mode_d       = mode_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    word_done_d  = word_done_q;
    under_pend_d = under_pend_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    rx_new       = 1'b0;
    load_tx      = 1'b0;
    under_ev     = 1'b0;
    ferr_ev      = 1'b0;

    if (tx_load && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (cs_fall && !active_q) begin
      active_d     = 1'b1;
      mode_d       = mode;
      cnt_d        = '0;
      pend_d       = mode[0];
      word_done_d  = 1'b0;
      under_pend_d = 1'b0;
      load_tx      = 1'b1;
      under_ev     = ~hold_full_q;
    end else if (active_q && cs_rise) begin
      active_d     = 1'b0;
      ferr_ev      = (cnt_q != '0);
      cnt_d        = '0;
      pend_d       = 1'b0;
      word_done_d  = 1'b0;
      under_pend_d = 1'b0;
    end else begin
      if (sample_ev) begin
        rx_sh_d = LSB_FIRST ? {sdi_sync_q[1], rx_sh_q[WIDTH-1:1]}
                            : {rx_sh_q[WIDTH-2:0], sdi_sync_q[1]};
        if (under_pend_q) begin
          under_ev     = 1'b1;
          under_pend_d = 1'b0;
        end
        if (cnt_q == LastBit) begin
          cnt_d       = '0;
          rx_new      = 1'b1;
          word_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      if (shift_ev) begin
        if (pend_q) begin
          pend_d = 1'b0;
        end else if (word_done_q) begin
          // The shift edge closing a word presents the first bit of the next one.
          word_done_d  = 1'b0;
          load_tx      = 1'b1;
          under_pend_d = ~hold_full_q;
        end else begin
          tx_sh_d = LSB_FIRST ? {1'b0, tx_sh_q[WIDTH-1:1]} : {tx_sh_q[WIDTH-2:0], 1'b0};
        end
      end
    end

    if (load_tx) begin
      tx_sh_d = hold_full_q ? hold_q : '0;
      if (hold_full_q) hold_full_d = 1'b0;
    end

    over_ev       = rx_new & rx_valid_q & ~rx_ack;
    rx_data_d     = rx_new ? rx_sh_d : rx_data_q;
    rx_valid_d    = rx_new | (rx_valid_q & ~rx_ack);
    rx_overrun_d  = (rx_overrun_q & ~clr_err) | over_ev;
    tx_underrun_d = (tx_underrun_q & ~clr_err) | under_ev;
    frame_err_d   = (frame_err_q & ~clr_err) | ferr_ev;
  end

  // State registers; CS synchroniser idles high so reset never looks like a frame
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sclk_sync_q   <= 2'b00;
      cs_sync_q     <= 2'b11;
      sdi_sync_q    <= 2'b00;
      sclk_dly_q    <= 1'b0;
      cs_dly_q      <= 1'b1;
      active_q      <= 1'b0;
      mode_q        <= 2'b00;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      word_done_q   <= 1'b0;
      under_pend_q  <= 1'b0;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      sdi_sync_q    <= sdi_sync_d;
      sclk_dly_q    <= sclk_dly_d;
      cs_dly_q      <= cs_dly_d;
      active_q      <= active_d;
      mode_q        <= mode_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      word_done_q   <= word_done_d;
      under_pend_q  <= under_pend_d;
      tx_sh_q       <= tx_sh_d;
      rx_sh_q       <= rx_sh_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_err   = frame_err_q;
  assign busy        = active_q;
  assign SDO         = active_q & ~pend_q & (LSB_FIRST ? tx_sh_q[0] : tx_sh_q[WIDTH-1]);

endmodule
